matrix_job_scheduler: RTL and testbench
=======================================

// Module: matrix_job_scheduler
// PURPOSE
//  Shares one matrix_accelerator_3x3 between NUM_REQ requesters.
//  - Round-robin arbitration over valid/ready job requests.
//  - Latches the winner's A/B operands and sequences the accelerator's start/done.
//  - Returns the 3x3 int32 result on a single response channel tagged with the requester id.
//  - Sits between the host/DMA request ports and the accelerator datapath.
// PARAMETERS
//  NUM_REQ     2    number of requesters (2..8)
//  ID_W        1    width of resp_id; must satisfy 2**ID_W >= NUM_REQ
//  TIMEOUT_CYC 64   WAIT-state watchdog limit in cycles (used only with the macro)
// PORTS
//  clk          in   1              clock, rising edge
//  rst_n        in   1              reset, asynchronous assert, active-low
//  req_valid    in   NUM_REQ        per-requester job valid
//  req_ready    out  NUM_REQ        one-hot accept pulse to the granted requester
//  req_mat_a    in   NUM_REQ*72     per-requester A: 9 x int8, row-major; element k at [72*i+8*k +: 8]
//  req_mat_b    in   NUM_REQ*72     per-requester B, same packing as req_mat_a
//  acc_start    out  1              one-cycle start pulse to the accelerator
//  acc_mat_a    out  72             latched A to the accelerator
//  acc_mat_b    out  72             latched B to the accelerator
//  acc_mat_c    in   288            accelerator result: 9 x int32, element k at [32*k +: 32]
//  acc_done     in   1              accelerator completion level/pulse
//  resp_valid   out  1              result available
//  resp_ready   in   1              consumer accepts the result
//  resp_id      out  ID_W           requester index owning the result
//  resp_mat_c   out  288            latched result
//  resp_err     out  1              job aborted by the watchdog (macro only; otherwise tied 0)
//  busy         out  1              high in any state other than IDLE
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - FSM=IDLE; all outputs 0.
//    - rr_ptr=NUM_REQ-1, so requester 0 has first priority.
//    - Reset mid-job abandons the job silently; no response is emitted.
//  - FSM states: IDLE -> LOAD -> START -> WAIT -> RESP -> IDLE.
//  - IDLE:
//    - If any req_valid is high, grant the first valid index after rr_ptr (wrap modulo NUM_REQ).
//    - In the same cycle: req_ready[g]=1, capture req_mat_a/b[g] and id g, set rr_ptr=g, go to LOAD.
//    - At most one req_ready bit is ever high, only in IDLE, and only for one cycle.
//  - LOAD:
//    - acc_mat_a/b drive the latched operands; go to START.
//    - Operands are stable from LOAD until the response is accepted.
//  - START: acc_start=1 for exactly 1 cycle; go to WAIT.
//    - Accept-to-start latency is 2 cycles (accept at T, acc_start at T+2).
//  - WAIT:
//    - On the first cycle acc_done=1, latch acc_mat_c into resp_mat_c; go to RESP.
//    - acc_done is ignored in all other states; a late or duplicate done is harmless.
//  - RESP:
//    - resp_valid=1; resp_id and resp_mat_c are held stable until resp_ready=1.
//    - On that handshake cycle go to IDLE; resp_valid drops the next cycle.
//    - A new grant is possible no earlier than the cycle after the handshake. No overlap of jobs.
//  - Fairness:
//    - With all requesters valid, grants rotate 0,1,..,NUM_REQ-1,0.
//    - A requester that drops valid is skipped without penalty.
//  - Datapath: no arithmetic on operands or results; bits pass through unchanged (sign preserved).
//  - busy = (state != IDLE).
// CONFIGURATION
//  Macro MATRIX_SCHED_TIMEOUT_EN:
//  - Defined:
//    - A watchdog counts cycles spent in WAIT.
//    - If it reaches TIMEOUT_CYC without acc_done, go to RESP with resp_err=1 and resp_mat_c=0.
//    - The counter clears on entry to WAIT.
//    - resp_err is cleared on the RESP handshake.
//  - Undefined: no counter; WAIT is held indefinitely; resp_err is tied 0.
// TESTING
//  1. Single job:
//     - Stimulus: req0, A=[1 2 3;4 5 6;7 8 9], B=[9 8 7;13 6 5;3 2 1].
//     - Required: req_ready[0] pulses once; acc_start 2 cycles later.
//     - Required: resp_id=0, resp_mat_c=[44 26 20;119 74 59;194 122 98].
//  2. Contention:
//     - Stimulus: req0 and req1 valid continuously from reset.
//     - Required: grants in order 0,1,0,1; one acc_start per grant; never two jobs in flight.
//  3. Response backpressure:
//     - Stimulus: resp_ready=0 for 10 cycles in RESP.
//     - Required: resp_valid, resp_id and resp_mat_c held stable; no new req_ready until the handshake.
//  4. Reset mid-job:
//     - Stimulus: drive rst_n low during WAIT.
//     - Required: all outputs 0 immediately; after release, req0 wins first; no stale resp_valid.
//  5. Second job reuse:
//     - Stimulus: req1, A=[1 2 0;3 4 0;0 0 0], B=[2 1 0;1 2 0;0 0 0].
//     - Required: resp_id=1, resp_mat_c=[4 5 0;10 11 0;0 0 0].
//  6. Watchdog (MATRIX_SCHED_TIMEOUT_EN):
//     - Stimulus: acc_done held 0.
//     - Required: resp_valid with resp_err=1 after TIMEOUT_CYC=64 WAIT cycles.
//     - Required: the next job completes normally with resp_err=0.

Source files
------------

// File: rtl/matrix_job_scheduler.sv
// Round-robin scheduler sharing one 3x3 matrix accelerator between NUM_REQ requesters.
// Optional WAIT-state watchdog enabled by defining MATRIX_SCHED_TIMEOUT_EN.
module matrix_job_scheduler #(
  parameter int NUM_REQ     = 2,
  parameter int ID_W        = 1,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*72-1:0]  req_mat_a,
  input  logic [NUM_REQ*72-1:0]  req_mat_b,
  output logic                   acc_start,
  output logic [71:0]            acc_mat_a,
  output logic [71:0]            acc_mat_b,
  input  logic [287:0]           acc_mat_c,
  input  logic                   acc_done,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [287:0]           resp_mat_c,
  output logic                   resp_err,
  output logic                   busy
);

  // Handshakes: a request transfers on the cycle req_valid[i] && req_ready[i];
  // a response transfers on the cycle resp_valid && resp_ready. Valid never
  // depends on ready on either channel.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t              r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic                r_accept_en;
  logic [71:0]         r_a;
  logic [71:0]         r_b;
  logic [ID_W-1:0]     r_id;
  logic [287:0]        r_c;
  logic                r_acc_start;
  logic                r_resp_valid;

  logic                w_any;
  logic [ID_W-1:0]     w_gnt_idx;
  logic [NUM_REQ-1:0]  w_gnt_vec;

`ifdef MATRIX_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0]     r_wd_cnt;
  logic                r_err;
`else
  logic                w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYC != 0);
`endif

  // Descending scan so the last hit is the nearest valid index after r_rr_ptr.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      int idx;
      idx = (int'(r_rr_ptr) + off) % NUM_REQ;
      if (req_valid[idx]) begin
        w_any     = 1'b1;
        w_gnt_idx = ID_W'(idx);
      end
    end
  end

  assign w_gnt_vec = NUM_REQ'(1) << w_gnt_idx;

  // r_accept_en is low for the first cycle after reset so every output is 0 in reset.
  assign req_ready  = (r_accept_en && w_any) ? w_gnt_vec : '0;
  assign acc_start  = r_acc_start;
  assign acc_mat_a  = r_a;
  assign acc_mat_b  = r_b;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_id;
  assign resp_mat_c = r_c;
  assign busy       = (r_state != S_IDLE);
`ifdef MATRIX_SCHED_TIMEOUT_EN
  assign resp_err   = r_err;
`else
  assign resp_err   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= ID_W'(NUM_REQ - 1);
      r_accept_en  <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_id         <= '0;
      r_c          <= '0;
      r_acc_start  <= 1'b0;
      r_resp_valid <= 1'b0;
`ifdef MATRIX_SCHED_TIMEOUT_EN
      r_wd_cnt     <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      r_acc_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_accept_en) begin
            r_accept_en <= 1'b1;
          end else if (w_any) begin
            r_a         <= req_mat_a[72*w_gnt_idx +: 72];
            r_b         <= req_mat_b[72*w_gnt_idx +: 72];
            r_id        <= w_gnt_idx;
            r_rr_ptr    <= w_gnt_idx;
            r_accept_en <= 1'b0;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_acc_start <= 1'b1;
          r_state     <= S_START;
        end
        S_START: begin
`ifdef MATRIX_SCHED_TIMEOUT_EN
          r_wd_cnt <= '0;
`endif
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (acc_done) begin
            r_c          <= acc_mat_c;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end
`ifdef MATRIX_SCHED_TIMEOUT_EN
          else if (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1)) begin
            r_c          <= '0;
            r_err        <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
          end else begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_accept_en  <= 1'b1;
`ifdef MATRIX_SCHED_TIMEOUT_EN
            r_err        <= 1'b0;
`endif
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_job_scheduler.sv
// Directed bench for matrix_job_scheduler with a behavioural accelerator and result scoreboard.
module tb_matrix_job_scheduler;
  localparam int NUM_REQ     = 2;
  localparam int ID_W        = 1;
  localparam int TIMEOUT_CYC = 64;
  localparam int SB_W        = 1 + ID_W + 288;

  typedef int mat_t [9];

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*72-1:0] req_mat_a;
  logic [NUM_REQ*72-1:0] req_mat_b;
  logic                  acc_start;
  logic [71:0]           acc_mat_a;
  logic [71:0]           acc_mat_b;
  logic [287:0]          acc_mat_c;
  logic                  acc_done;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [287:0]          resp_mat_c;
  logic                  resp_err;
  logic                  busy;

  logic [71:0]  ra0, rb0, ra1, rb1;
  logic [71:0]  a1, b1, a5, b5, an, bi;
  logic [287:0] c1, c5, cn;
  assign req_mat_a = {ra1, ra0};
  assign req_mat_b = {rb1, rb0};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [SB_W-1:0] exp_q[$];
  int grant_log[$];
  int grant_cyc, start_cyc, n_starts;
  bit in_flight;
  int jobs_left [NUM_REQ];
  bit acc_hang, acc_dup;
  int acc_lat = 3;

  matrix_job_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mat_a(req_mat_a), .req_mat_b(req_mat_b),
    .acc_start(acc_start), .acc_mat_a(acc_mat_a), .acc_mat_b(acc_mat_b),
    .acc_mat_c(acc_mat_c), .acc_done(acc_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_mat_c(resp_mat_c), .resp_err(resp_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [71:0] pack8(input mat_t e);
    logic [71:0] v;
    for (int k = 0; k < 9; k++) v[8*k +: 8] = 8'(e[k]);
    return v;
  endfunction

  function automatic logic [287:0] pack32(input mat_t e);
    logic [287:0] v;
    for (int k = 0; k < 9; k++) v[32*k +: 32] = 32'(e[k]);
    return v;
  endfunction

  function automatic logic [287:0] matmul(input logic [71:0] a, input logic [71:0] b);
    logic [287:0] v;
    int s;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        s = 0;
        for (int k = 0; k < 3; k++)
          s += int'($signed(a[8*(3*r+k) +: 8])) * int'($signed(b[8*(3*k+c) +: 8]));
        v[32*(3*r+c) +: 32] = s;
      end
    return v;
  endfunction

  // driver: one clock, retiring requests that were accepted on that edge
  task automatic tick();
    logic [NUM_REQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (acc[i]) begin
        jobs_left[i]--;
        if (jobs_left[i] <= 0) req_valid[i] = 1'b0;
      end
  endtask

  task automatic wait_idle(input string tag, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy && req_valid == '0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    chk(tag, done, 1'b1);
  endtask

  // behavioural accelerator
  initial begin
    acc_done  = 1'b0;
    acc_mat_c = '0;
    forever begin
      @(negedge clk);
      if (acc_start && !acc_hang) begin
        repeat (acc_lat) @(negedge clk);
        acc_mat_c = matmul(acc_mat_a, acc_mat_b);
        acc_done  = 1'b1;
        @(negedge clk);
        if (acc_dup) @(negedge clk);
        acc_done  = 1'b0;
      end
    end
  end

  // monitor + scoreboard
  initial begin
    int g, pending;
    forever begin
      @(negedge clk);
      if (req_ready != '0) begin
        chk("ready_onehot", $onehot(req_ready), 1'b1);
        chk("ready_only_idle", busy, 1'b0);
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) grant_log.push_back(i);
        grant_cyc = cyc;
      end
      if (acc_start) begin
        chk("no_overlap", in_flight, 1'b0);
        chk("start_latency", cyc - grant_cyc, 2);
        g = (grant_log.size() > 0) ? grant_log[grant_log.size()-1] : 0;
        chk("acc_operands", {acc_mat_a, acc_mat_b}, (g == 0) ? {ra0, rb0} : {ra1, rb1});
        in_flight = 1'b1;
        start_cyc = cyc;
        n_starts++;
      end
      if (resp_valid && resp_ready) begin
        pending = exp_q.size();
        chk("resp_pending", pending != 0, 1'b1);
        if (pending != 0) chk("resp", {resp_err, resp_id, resp_mat_c}, exp_q.pop_front());
        in_flight = 1'b0;
      end
    end
  end

  initial begin
    mat_t m;
    bit seen;
    m = '{1, 2, 3, 4, 5, 6, 7, 8, 9};             a1 = pack8(m);
    m = '{9, 8, 7, 13, 6, 5, 3, 2, 1};            b1 = pack8(m);
    m = '{44, 26, 20, 119, 74, 59, 194, 122, 98}; c1 = pack32(m);
    m = '{1, 2, 0, 3, 4, 0, 0, 0, 0};             a5 = pack8(m);
    m = '{2, 1, 0, 1, 2, 0, 0, 0, 0};             b5 = pack8(m);
    m = '{4, 5, 0, 10, 11, 0, 0, 0, 0};           c5 = pack32(m);
    m = '{-1, 2, -3, 4, -5, 6, -7, 8, -9};        an = pack8(m);
    cn = pack32(m);
    m = '{1, 0, 0, 0, 1, 0, 0, 0, 1};             bi = pack8(m);

    ra0 = a1; rb0 = b1; ra1 = a5; rb1 = b5;
    req_valid = '0; resp_ready = 1'b1; acc_hang = 1'b0; acc_dup = 1'b0;
    in_flight = 1'b0; n_starts = 0; grant_cyc = 0; start_cyc = 0;
    for (int i = 0; i < NUM_REQ; i++) jobs_left[i] = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {req_ready, acc_start, acc_mat_a, acc_mat_b, resp_valid,
                          resp_id, resp_mat_c, resp_err, busy}, '0);
    rst_n = 1'b1;

    // single job on requester 0
    exp_q.push_back({1'b0, ID_W'(0), c1});
    jobs_left[0] = 1; req_valid[0] = 1'b1;
    wait_idle("t1_done", 100);
    chk("t1_grants", grant_log.size(), 1);
    chk("t1_grant_id", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    chk("t1_starts", n_starts, 1);
    chk("t1_resp_dropped", resp_valid, 1'b0);

    // second job on requester 1
    grant_log.delete(); n_starts = 0;
    exp_q.push_back({1'b0, ID_W'(1), c5});
    jobs_left[1] = 1; req_valid[1] = 1'b1;
    wait_idle("t5_done", 100);
    chk("t5_grant_id", (grant_log.size() == 1) ? grant_log[0] : -1, 1);

    // reset during WAIT, then contention straight out of reset
    grant_log.delete(); n_starts = 0; acc_hang = 1'b1;
    jobs_left[0] = 1; req_valid[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); seen = in_flight; end
    chk("t4_started", seen, 1'b1);
    repeat (3) tick();
    chk("t4_in_wait", {busy, resp_valid}, 2'b10);
    jobs_left[0] = 2; jobs_left[1] = 2; req_valid = '1;
    rst_n = 1'b0;
    #1;
    chk("t4_reset_outputs", {req_ready, acc_start, acc_mat_a, acc_mat_b, resp_valid,
                             resp_id, resp_mat_c, resp_err, busy}, '0);
    in_flight = 1'b0; grant_log.delete(); n_starts = 0;
    tick(); tick();
    acc_hang = 1'b0; acc_dup = 1'b1;
    exp_q.push_back({1'b0, ID_W'(0), c1});
    exp_q.push_back({1'b0, ID_W'(1), c5});
    exp_q.push_back({1'b0, ID_W'(0), c1});
    exp_q.push_back({1'b0, ID_W'(1), c5});
    rst_n = 1'b1;
    tick();
    chk("t4_no_stale_resp", resp_valid, 1'b0);
    wait_idle("t2_done", 300);
    chk("t2_grant_count", grant_log.size(), 4);
    chk("t2_order", (grant_log.size() == 4) ?
        {grant_log[0][3:0], grant_log[1][3:0], grant_log[2][3:0], grant_log[3][3:0]} : 16'hffff,
        16'h0101);
    chk("t2_starts", n_starts, 4);
    acc_dup = 1'b0;

    // response backpressure, signed operands
    grant_log.delete(); n_starts = 0;
    ra0 = an; rb0 = bi; resp_ready = 1'b0;
    exp_q.push_back({1'b0, ID_W'(0), cn});
    exp_q.push_back({1'b0, ID_W'(1), c5});
    jobs_left[0] = 1; jobs_left[1] = 1; req_valid = '1;
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin tick(); seen = resp_valid; end
    chk("t3_resp_seen", seen, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", resp_valid, 1'b1);
      chk("t3_hold_data", {resp_err, resp_id, resp_mat_c}, {1'b0, ID_W'(0), cn});
      chk("t3_no_grant", req_ready, '0);
      tick();
    end
    resp_ready = 1'b1;
    wait_idle("t3_done", 100);
    chk("t3_order", (grant_log.size() == 2) ? {grant_log[0][3:0], grant_log[1][3:0]} : 8'hff, 8'h01);

`ifdef MATRIX_SCHED_TIMEOUT_EN
    // watchdog
    acc_hang = 1'b1;
    exp_q.push_back({1'b1, ID_W'(0), 288'd0});
    jobs_left[0] = 1; req_valid[0] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 120 && !seen; i++) begin tick(); seen = resp_valid; end
    chk("t6_resp_seen", seen, 1'b1);
    chk("t6_wd_latency", cyc - start_cyc, TIMEOUT_CYC + 1);
    chk("t6_err", resp_err, 1'b1);
    wait_idle("t6_done", 20);
    acc_hang = 1'b0;
    exp_q.push_back({1'b0, ID_W'(0), cn});
    jobs_left[0] = 1; req_valid[0] = 1'b1;
    wait_idle("t6_next_done", 100);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
